right_shift_seq: RTL
====================

# right_shift_seq

Multi-cycle right shifter, the inverse-direction companion to the team's combinational left shifter. It shifts a captured switch word right by `shamt` positions, one bit per clock, in either logical or arithmetic mode. It presents the result on the LED bus with a start/ready/done handshake, so it can sit behind a debounced push-button or another control FSM on the board.

## Interface
- `WIDTH`, default 4: data width, sw/led width; must be ≥ 2.
- `SHW`, default `$clog2(WIDTH)`: shift-amount width; 2 at default.

- `clk`  in  1  single system clock; all state on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `sw`  in  WIDTH  operand, sampled only on an accepted start.
- `shamt`  in  SHW  shift amount, 0..WIDTH-1, sampled on an accepted start.
- `arith`  in  1  1 = arithmetic (MSB fill), 0 = logical (zero fill); sampled on an accepted start.
- `start`  in  1  request; accepted on a rising edge where `start && ready`.
- `ready`  out  1  high only in IDLE.
- `busy`  out  1  high in SHIFT and DONE; equals `~ready`.
- `done`  out  1  one-cycle pulse; `led` is valid and new in that cycle.
- `led`  out  WIDTH  last completed result, registered, held until the next completion.

## Operation
- States are IDLE, SHIFT and DONE.
- IDLE:
  - On an accepted start, latch `sw` into the working register, `shamt` into the down-counter, and `arith`.
  - Next state is SHIFT if `shamt != 0`, else DONE.
  - Without start, remain in IDLE.
- SHIFT, each cycle:
  - The working register shifts right by 1.
  - Fill bit is the working register MSB if arith, else 0.
  - The counter decrements.
  - When the counter equals 1 on an edge, that edge performs the final shift and enters DONE.
- DONE:
  - `done=1` for exactly one cycle.
  - `led` already holds the result; it is loaded on the edge that enters DONE.
  - Next state is IDLE unconditionally.
- Result:
  - Logical mode equals `sw >> shamt`.
  - Arithmetic mode equals `$signed(sw) >>> shamt`.
  - No bits are kept beyond WIDTH; shifted-out bits are discarded.
- `start` while busy is ignored: not queued, no effect on the in-flight operation.
- `sw`, `shamt` and `arith` changing while busy have no effect.

## Timing
- Reset values: state IDLE, `ready=1`, `busy=0`, `done=0`, `led=0`, counter 0, working register 0.
- Start is sampled high in cycle 0.
- Cycles 1..shamt are SHIFT cycles.
- `done` and the new `led` appear in cycle shamt+1.
- For shamt=0, done and led=sw appear in cycle 1.
- `ready` returns in cycle shamt+2; earliest next accept is at the end of that cycle.
- Throughput is one operation per shamt+2 cycles.
- `led` changes only on the edge entering DONE, or on reset.
- Reset mid-operation, in any state including DONE:
  - Abort the operation.
  - Return to IDLE with `led=0` and no done pulse.
  - Reset has priority over start on the same edge.
- Maximum latency is WIDTH cycles from start to done, at shamt=WIDTH-1.

## Structure
- Shared package `shift_pkg`:
  - `typedef enum logic [1:0] {IDLE, SHIFT, DONE} shift_state_t`, also reused by the left shifter's future sequential variant.
  - Localparam for default WIDTH.
- Internals are one state register, a WIDTH-bit working register, an SHW-bit down-counter, and a latched arith bit.
- `ready`, `busy` and `done` decode combinationally from state.
- One natural sub-module: `shift_counter`, a loadable SHW-bit down-counter with a `last` flag. It is optional; inlining is acceptable if under ~20 lines.

## Test plan
- Logical shift: sw=4'b1011, shamt=2, arith=0, start in cycle 0. Required: done high only in cycle 3, led=4'b0010, ready high again in cycle 4.
- Arithmetic shift: sw=4'b1011, shamt=3, arith=1. Required: done in cycle 4, led=4'b1111. Repeat with sw=4'b0110 → led=4'b0000.
- Zero shift: sw=4'b1001, shamt=0. Required: done in cycle 1, led=4'b1001, busy high in cycle 1 only.
- Start while busy: accept sw=4'b1100, shamt=3. Then pulse start with sw=4'b0001, shamt=0 in cycle 2. Required: ignored, single done in cycle 4 with led=4'b0001 (1100>>3), and no second done.
- Reset mid-operation: accept sw=4'b1111, shamt=3, then assert reset in cycle 2. Required: next cycle ready=1, led=4'b0000, no done pulse ever for that request.
- Back-to-back with led hold: accept sw=4'b1000, shamt=1 (led=4'b0100 at done). Hold start high continuously. Required: second accept at the end of cycle 3, led stays 4'b0100 until the next done.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the shifter family: the sequencing states and
// the default data width.
package shift_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } shift_state_t;

  // Bit shifted in at the MSB on a one-position right shift.
  function automatic logic fill_bit(input logic arith, input logic msb);
    return arith & msb;
  endfunction

endpackage

// File: rtl/shift_counter.sv
// Loadable down-counter that tracks the remaining shift steps; 'last' flags
// the step that completes the operation.
module shift_counter #(
  parameter int SHW = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load,
  input  logic [SHW-1:0] load_val,
  input  logic           dec,
  output logic           last
);

  logic [SHW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec) begin
      count <= count - 1'b1;
    end
  end

  assign last = (count == SHW'(1));

endmodule

// File: rtl/right_shift_seq.sv
// Multi-cycle right shifter: shifts a captured word one bit per clock in
// logical or arithmetic mode and presents the result behind a start/done handshake.
module right_shift_seq
  import shift_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw,
  input  logic [SHW-1:0]   shamt,
  input  logic             arith,
  input  logic             start,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] led
);

  shift_state_t     state, state_next;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] work_shifted;
  logic             arith_q;

  logic             load;
  logic             shift_en;
  logic             led_load;
  logic [WIDTH-1:0] led_val;
  logic             last;

  shift_counter #(.SHW(SHW)) u_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (shamt),
    .dec      (shift_en),
    .last     (last)
  );

  assign work_shifted = {fill_bit(arith_q, work[WIDTH-1]), work[WIDTH-1:1]};

  // NOTE: state is registered with non-blocking assignments so every flop
  // samples the pre-edge values, regardless of block ordering in simulation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every output of this block is given a default before the case so
  // no path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    shift_en   = 1'b0;
    led_load   = 1'b0;
    led_val    = work_shifted;
    unique case (state)
      IDLE: begin
        if (start) begin
          load = 1'b1;
          if (shamt != '0) begin
            state_next = SHIFT;
          end else begin
            // Zero shift skips SHIFT, so the operand goes straight to the LEDs.
            state_next = DONE;
            led_load   = 1'b1;
            led_val    = sw;
          end
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (last) begin
          state_next = DONE;
          led_load   = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      work    <= '0;
      arith_q <= 1'b0;
      led     <= '0;
    end else begin
      if (load) begin
        work    <= sw;
        arith_q <= arith;
      end else if (shift_en) begin
        work <= work_shifted;
      end
      if (led_load) begin
        led <= led_val;
      end
    end
  end

  assign ready = (state == IDLE);
  assign busy  = ~ready;
  assign done  = (state == DONE);

endmodule
